timer_compare_irq: RTL and testbench
====================================

// Module: timer_compare_irq
// PURPOSE
//  Compare/interrupt stage downstream of the 64-bit timer counter. Consumes the live count
//  {TDR1,TDR0} and holds a 64-bit compare value {TCMP1,TCMP0} plus a 32-bit period register.
//  Raises a sticky match status and a level interrupt; optional auto-reload advances the
//  compare value by the period on each match, giving periodic interrupts without SW reload.
// PARAMETERS
//  CMP_RST   64'hFFFF_FFFF_FFFF_FFFF  reset value of {tcmp1,tcmp0}
//  PER_RST   32'h0000_0000            reset value of tper
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, asynchronous, active-low
//  cnt         in   64  live counter value from counter stage, registered upstream
//  tcmp0_wr_en in   1   write strobe, compare low word
//  tcmp1_wr_en in   1   write strobe, compare high word
//  tper_wr_en  in   1   write strobe, period register
//  tctl_wr_en  in   1   write strobe, control: bit0 int_en, bit1 ar_en
//  tisr_wr_en  in   1   write strobe, status: write-1-to-clear on bit0
//  mask        in   32  byte-lane bit mask of the bus write
//  wdata_mask  in   32  write data already ANDed with mask
//  tcmp0       out  32  compare low word
//  tcmp1       out  32  compare high word
//  tper        out  32  period register
//  int_en      out  1   interrupt enable
//  ar_en       out  1   auto-reload enable
//  int_st      out  1   sticky match status
//  tim_int     out  1   interrupt = int_en & int_st
// BEHAVIOUR
//  Reset: {tcmp1,tcmp0}=CMP_RST, tper=PER_RST, int_en=0, ar_en=0, int_st=0, match_q=0, tim_int=0.
//  Masked write, all RW regs: reg <= (reg & ~mask) | wdata_mask; no strobe -> hold.
//  tctl write: updates only bits [1:0] via the same formula; other bits ignored.
//  match = (cnt == {tcmp1,tcmp0}), full 64-bit compare, combinational.
//  match_q <= match each cycle; match_rise = match & ~match_q.
//  int_st set: match_rise in cycle N -> int_st=1 from cycle N+1. Holding counter on cmp
//   never re-sets it.
//  int_st clear: tisr_wr_en & wdata_mask[0] -> 0 next cycle.
//   Set and clear in the same cycle: set wins, int_st=1.
//  int_st is set regardless of int_en; tim_int = int_en & int_st, combinational from regs.
//   Setting int_en with int_st=1 asserts tim_int next cycle.
//  Auto-reload, all of ar_en=1, match_rise, and no tcmp0/tcmp1 write that cycle:
//   {tcmp1,tcmp0} <= {tcmp1,tcmp0} + {32'h0,tper}, modulo 2^64, carry into tcmp1.
//   Takes effect cycle N+1, so match deasserts unless cnt also advances to the new value.
//  Write vs reload same cycle: the SW write wins on the written word.
//   The unwritten word holds; no partial reload.
//  tper=0 with ar_en=1: compare unchanged, match stays high, no further rise, single event.
//  Compare write making cnt==cmp immediately: match rises next eval, status set as normal.
//  Wrap-around: cmp+tper overflow past 2^64 wraps; matches when the counter wraps to it.
//  Counter cleared or written upstream: only equality matters; jumps onto cmp give a rise,
//   jumps over cmp give no event.
//  Async reset mid-operation: all state returns to reset values immediately, tim_int=0
//   while rst_n low.
//  No multicycle paths; all outputs except match/tim_int are direct register outputs.
// TESTING
//  1 Reset: outputs = reset values; tcmp=all-ones, tim_int=0; assert rst_n mid-match
//    -> int_st=0.
//  2 Byte write: tcmp0=32'h1234_5678, mask=32'h0000_FF00, wdata_mask=32'h0000_AB00
//    -> tcmp0=32'h1234_AB78.
//  3 One-shot: cmp=64'd10, int_en=1, cnt ramps 0..20 -> int_st/tim_int rise the cycle
//    after cnt=10. W1C while cnt holds at 10 -> int_st stays 0.
//  4 Periodic: cmp=64'd5, tper=32'd5, ar_en=1, counter free-runs -> status rises after
//    cnt=5,10,15. W1C between events -> cmp reads 10,15,20 in turn.
//  5 Carry: cmp=64'h0000_0000_FFFF_FFFE, tper=4, ar_en=1, match -> cmp=64'h0000_0001_0000_0002.
//  6 Collisions: W1C on the cycle of match_rise -> int_st=1.
//    tcmp0 write on the reload cycle -> tcmp0=written value, tcmp1 unchanged.

Source files
------------

// File: rtl/timer_compare_irq.sv
// timer_compare_irq: 64-bit compare against the live count with sticky status, level irq and auto-reload
module timer_compare_irq #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [31:0] PER_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] cnt,
  input  logic        tcmp0_wr_en,
  input  logic        tcmp1_wr_en,
  input  logic        tper_wr_en,
  input  logic        tctl_wr_en,
  input  logic        tisr_wr_en,
  input  logic [31:0] mask,
  input  logic [31:0] wdata_mask,
  output logic [31:0] tcmp0,
  output logic [31:0] tcmp1,
  output logic [31:0] tper,
  output logic        int_en,
  output logic        ar_en,
  output logic        int_st,
  output logic        tim_int
);
  logic        match, match_q, match_rise, reload;
  logic [63:0] cmp_next;
  assign match      = cnt == {tcmp1, tcmp0};
  assign match_rise = match & ~match_q;
  // any SW write to either compare word suppresses the whole reload, so no word is half-advanced
  assign reload     = ar_en & match_rise & ~tcmp0_wr_en & ~tcmp1_wr_en;
  assign cmp_next   = {tcmp1, tcmp0} + {32'h0, tper};
  assign tim_int    = int_en & int_st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {tcmp1, tcmp0} <= CMP_RST;
      tper           <= PER_RST;
      int_en         <= 1'b0;
      ar_en          <= 1'b0;
      int_st         <= 1'b0;
      match_q        <= 1'b0;
    end else begin
      match_q <= match;
      tcmp0   <= tcmp0_wr_en ? (tcmp0 & ~mask) | wdata_mask : reload ? cmp_next[31:0] : tcmp0;
      tcmp1   <= tcmp1_wr_en ? (tcmp1 & ~mask) | wdata_mask : reload ? cmp_next[63:32] : tcmp1;
      tper    <= tper_wr_en ? (tper & ~mask) | wdata_mask : tper;
      int_en  <= tctl_wr_en ? (int_en & ~mask[0]) | wdata_mask[0] : int_en;
      ar_en   <= tctl_wr_en ? (ar_en & ~mask[1]) | wdata_mask[1] : ar_en;
      int_st  <= match_rise ? 1'b1 : (tisr_wr_en & wdata_mask[0]) ? 1'b0 : int_st;
    end
endmodule

// File: tb/tb_timer_compare_irq.sv
// tb_timer_compare_irq: directed vectors with hand-computed expectations for timer_compare_irq
module tb_timer_compare_irq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] cnt = '0;
  logic        tcmp0_wr_en = 1'b0, tcmp1_wr_en = 1'b0, tper_wr_en = 1'b0, tctl_wr_en = 1'b0, tisr_wr_en = 1'b0;
  logic [31:0] mask = '0, wdata_mask = '0;
  logic [31:0] tcmp0, tcmp1, tper;
  logic        int_en, ar_en, int_st, tim_int;
  int          checks = 0, errors = 0;

  timer_compare_irq dut (
    .clk(clk), .rst_n(rst_n), .cnt(cnt),
    .tcmp0_wr_en(tcmp0_wr_en), .tcmp1_wr_en(tcmp1_wr_en), .tper_wr_en(tper_wr_en),
    .tctl_wr_en(tctl_wr_en), .tisr_wr_en(tisr_wr_en), .mask(mask), .wdata_mask(wdata_mask),
    .tcmp0(tcmp0), .tcmp1(tcmp1), .tper(tper), .int_en(int_en), .ar_en(ar_en),
    .int_st(int_st), .tim_int(tim_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 tcmp0, 1 tcmp1, 2 tper, 3 tctl, 4 tisr
  task automatic wr(input int sel, input logic [31:0] m, input logic [31:0] d);
    tcmp0_wr_en = sel == 0;
    tcmp1_wr_en = sel == 1;
    tper_wr_en  = sel == 2;
    tctl_wr_en  = sel == 3;
    tisr_wr_en  = sel == 4;
    mask = m;
    wdata_mask = d & m;
    tick();
    {tcmp0_wr_en, tcmp1_wr_en, tper_wr_en, tctl_wr_en, tisr_wr_en} = '0;
    mask = '0;
    wdata_mask = '0;
  endtask

  initial begin
    #12;
    check("rst_tcmp0", tcmp0, 64'hFFFF_FFFF);
    check("rst_tcmp1", tcmp1, 64'hFFFF_FFFF);
    check("rst_tper", tper, 0);
    check("rst_ctl", {int_en, ar_en}, 0);
    check("rst_int_st", int_st, 0);
    check("rst_tim_int", tim_int, 0);
    rst_n = 1'b1;
    tick();
    // byte-lane write
    wr(0, 32'hFFFF_FFFF, 32'h1234_5678);
    wr(0, 32'h0000_FF00, 32'h0000_AB00);
    check("byte_wr", tcmp0, 64'h1234_AB78);
    // one-shot at cmp=10
    wr(1, 32'hFFFF_FFFF, 32'h0);
    wr(0, 32'hFFFF_FFFF, 32'd10);
    wr(3, 32'h1, 32'h1);
    check("int_en_set", {int_en, ar_en}, 2'b10);
    for (int i = 0; i <= 20; i++) begin
      cnt = 64'(i);
      tick();
      if (i == 9) check("os_before", int_st, 0);
      if (i == 10) begin
        check("os_int_st", int_st, 1);
        check("os_tim_int", tim_int, 1);
        check("os_cmp_held", tcmp0, 10);
      end
      if (i == 20) check("os_sticky", int_st, 1);
    end
    cnt = 64'd10;
    tick();
    wr(4, 32'h1, 32'h1);
    check("w1c_clr", int_st, 0);
    tick();
    tick();
    check("hold_no_reset", int_st, 0);
    check("hold_tim_int", tim_int, 0);
    // async reset while status is set
    cnt = 64'd0;
    tick();
    cnt = 64'd10;
    tick();
    check("pre_rst_st", int_st, 1);
    rst_n = 1'b0;
    #2;
    check("arst_int_st", int_st, 0);
    check("arst_tim_int", tim_int, 0);
    check("arst_tcmp0", tcmp0, 64'hFFFF_FFFF);
    check("arst_int_en", int_en, 0);
    cnt = 64'd0;
    rst_n = 1'b1;
    tick();
    // periodic: cmp=5, tper=5, auto-reload
    wr(1, 32'hFFFF_FFFF, 32'h0);
    wr(0, 32'hFFFF_FFFF, 32'd5);
    wr(2, 32'hFFFF_FFFF, 32'd5);
    wr(3, 32'h2, 32'h2);
    check("ar_en_set", {int_en, ar_en}, 2'b01);
    for (int i = 0; i <= 21; i++) begin
      cnt = 64'(i);
      if (i == 7 || i == 12) wr(4, 32'h1, 32'h1);
      else tick();
      case (i)
        4:  check("per_pre", int_st, 0);
        5:  begin check("per_st5", int_st, 1); check("per_cmp10", tcmp0, 10); check("per_noint", tim_int, 0); end
        7:  check("per_clr7", int_st, 0);
        9:  check("per_quiet9", int_st, 0);
        10: begin check("per_st10", int_st, 1); check("per_cmp15", tcmp0, 15); end
        12: check("per_clr12", int_st, 0);
        15: begin check("per_st15", int_st, 1); check("per_cmp20", tcmp0, 20); end
        default: ;
      endcase
    end
    cnt = 64'd0;
    wr(4, 32'h1, 32'h1);
    // carry into tcmp1
    wr(2, 32'hFFFF_FFFF, 32'd4);
    wr(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check("cy_pre_st", int_st, 0);
    cnt = 64'h0000_0000_FFFF_FFFE;
    tick();
    check("cy_cmp", {tcmp1, tcmp0}, 64'h0000_0001_0000_0002);
    check("cy_st", int_st, 1);
    // tper=0: single event, compare unchanged
    wr(2, 32'hFFFF_FFFF, 32'd0);
    wr(4, 32'h1, 32'h1);
    cnt = 64'h0000_0001_0000_0002;
    tick();
    check("p0_st", int_st, 1);
    check("p0_cmp", {tcmp1, tcmp0}, 64'h0000_0001_0000_0002);
    wr(4, 32'h1, 32'h1);
    tick();
    tick();
    check("p0_no_rerise", int_st, 0);
    check("p0_cmp_hold", {tcmp1, tcmp0}, 64'h0000_0001_0000_0002);
    // W1C on the rise cycle: set wins
    cnt = 64'd0;
    tick();
    cnt = 64'h0000_0001_0000_0002;
    wr(4, 32'h1, 32'h1);
    check("coll_w1c", int_st, 1);
    // setting int_en with status pending raises irq; bit1 untouched by mask
    wr(3, 32'h1, 32'h1);
    check("late_en_irq", tim_int, 1);
    check("late_en_ar", ar_en, 1);
    // tcmp0 write on reload cycle: write wins, tcmp1 does not take the carry
    cnt = 64'd0;
    wr(2, 32'hFFFF_FFFF, 32'd4);
    wr(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    cnt = 64'h0000_0001_FFFF_FFFE;
    wr(0, 32'hFFFF_FFFF, 32'hAAAA_0000);
    check("coll_tcmp0", tcmp0, 64'hAAAA_0000);
    check("coll_tcmp1", tcmp1, 64'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
